// File: rtl/jtkunio_sndcmd_if.sv
// Bus bundle between the main CPU sound latch, the sound CPU and the command FIFO.
interface jtkunio_sndcmd_if #(
  parameter int DEPTH = 4
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          main_wr;
  logic [7:0]    main_din;
  logic          snd_rd;
  logic          stat_rd;
  logic [7:0]    snd_dout;
  logic [7:0]    snd_stat;
  logic          snd_irq;
  logic [AW:0]   level;
  logic          overflow;

  // CPU side: drives the access decodes and data, observes the channel.
  modport master (
    output main_wr, main_din, snd_rd, stat_rd,
    input  snd_dout, snd_stat, snd_irq, level, overflow
  );

  // Channel side: the command FIFO itself.
  modport slave (
    input  main_wr, main_din, snd_rd, stat_rd,
    output snd_dout, snd_stat, snd_irq, level, overflow
  );
endinterface

// File: rtl/jtkunio_sndcmd.sv
// Sound-command FIFO: main CPU latch writes are queued, the sound CPU reads the
// oldest byte and gets an IRQ while commands are pending, with a guaranteed
// IRQ-low gap after each read so the ISR can return before re-entry.
module jtkunio_sndcmd #(
  parameter int DEPTH   = 4,
  parameter int IRQ_GAP = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic snd_cen,
  jtkunio_sndcmd_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam int GW = (IRQ_GAP > 0) ? $clog2(IRQ_GAP + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // Pointers wrap modulo DEPTH, which need not fill the pointer width.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  logic          wr_q, rd_q, stat_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    dout_q;
  logic [7:0]    mem_q [DEPTH];
  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          irq_q, irq_d;

  logic push_edge, pop_edge, stat_fall;
  logic full, empty, do_push, do_pop, ovf_set;
  logic [4:0] lvl_ext;
  logic [2:0] lvl_sat;

  // Edge detection: push on main_wr rise, pop and status clear on falling ends.
  assign push_edge = bus.main_wr & ~wr_q;
  assign pop_edge  = ~bus.snd_rd & rd_q;
  assign stat_fall = ~bus.stat_rd & stat_q;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop_edge & ~empty;
  // A same-clk pop frees the slot, so a push at full is still accepted.
  assign do_push = push_edge & (~full | do_pop);
  assign ovf_set = push_edge & full & ~do_pop;

  // Register previous access-decode levels for edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      stat_q <= 1'b0;
    end else begin
      wr_q   <= bus.main_wr;
      rd_q   <= bus.snd_rd;
      stat_q <= bus.stat_rd;
    end
  end

  // Next pointers, fill level and sticky overflow (set beats clear).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (ovf_set)        ovf_d = 1'b1;
    else if (stat_fall) ovf_d = 1'b0;
  end

  // FIFO bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array written at the tail on an accepted push.
  // NOTE: the array has no reset; entries are only read once level marks them valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= bus.main_din;
  end

  // Head byte register: follows the head while data exists, holds when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dout_q <= 8'h00;
    else if (!empty) dout_q <= mem_q[rd_ptr_q];
  end

  // IRQ FSM state register, gap counter and registered IRQ output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      irq_q   <= irq_d;
    end
  end

  // IRQ FSM next state: assert while pending, enforce the post-pop gap.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (do_pop) begin
          state_d = ST_GAP;
          gap_d   = GW'(IRQ_GAP);
        end
      end
      ST_GAP: begin
        if (gap_q == '0)  state_d = empty ? ST_IDLE : ST_ASSERT;
        else if (snd_cen) gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // IRQ FSM output: decode the upcoming state so the IRQ pin is a flop.
  always_comb begin
    irq_d = (state_d == ST_ASSERT);
  end

  // Status byte level field saturates at 7.
  assign lvl_ext = 5'(level_q);
  assign lvl_sat = (lvl_ext > 5'd7) ? 3'd7 : lvl_ext[2:0];

  assign bus.snd_dout = dout_q;
  assign bus.snd_stat = {ovf_q, 4'd0, lvl_sat};
  assign bus.snd_irq  = irq_q;
  assign bus.level    = level_q;
  assign bus.overflow = ovf_q;
endmodule
